// File: rtl/regpair_file_gen.sv
// Register-pair file with shared dreg latch and serial/parallel inc/dec unit.
// Optional XCHG between two pairs is enabled by defining REGPAIR_SWAP_EN.
module regpair_file_gen #(
    parameter int BYTE_W    = 8,
    parameter int NUM_PAIRS = 6,
    parameter int SERIAL    = 1,
    parameter int PSEL_W    = $clog2(NUM_PAIRS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PSEL_W-1:0] pair_sel,
    input  logic              pair_rd,
    input  logic              pair_wr,
    input  logic              lo_rd,
    input  logic              hi_rd,
    input  logic              lo_wr,
    input  logic              hi_wr,
    input  logic [BYTE_W-1:0] dbus_in,
    output logic [BYTE_W-1:0] dbus_out,
    output logic              dbus_oe,
    input  logic              incdec_req,
    input  logic              incdec_dir,
    input  logic              incdec_step2,
    input  logic              incdec_wb,
    output logic              incdec_busy,
    output logic              incdec_done,
`ifdef REGPAIR_SWAP_EN
    input  logic              swap_req,
    input  logic [PSEL_W-1:0] swap_sel,
`endif
    output logic              zero,
    output logic [2*BYTE_W-1:0] address
);

    localparam int DW = 2 * BYTE_W;

    typedef enum logic [1:0] {IDLE, LO, HI, EXEC} state_t;

    state_t state, state_nx;

    logic [DW-1:0]     pairs [NUM_PAIRS];
    logic [DW-1:0]     dreg;
    logic [DW-1:0]     rd_val;
    logic [DW-1:0]     res;
    logic [DW-1:0]     full_res;
    logic [DW-1:0]     step_w;
    logic [BYTE_W:0]   step_b;
    logic [BYTE_W:0]   lo_sum;
    logic [BYTE_W-1:0] hi_res;
    logic              carry_q;
    logic              dir_q;
    logic              step2_q;
    logic              wb_q;
    logic [PSEL_W-1:0] wb_sel;
    logic              done_q;
    logic              busy;
    logic              fin;
    logic              wb_fire;
    logic              swap_go;
    logic [DW-1:0]     sw_val;

    assign busy        = (state != IDLE);
    assign fin         = (state == HI) || (state == EXEC);
    assign wb_fire     = fin && wb_q;
    assign incdec_busy = busy;
    assign incdec_done = done_q;
    assign zero        = (dreg == '0);
    assign address     = dreg;

    // Selected pair value; out-of-range selects read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_PAIRS; i++)
            if (pair_sel == PSEL_W'(i)) rd_val = pairs[i];
    end

`ifdef REGPAIR_SWAP_EN
    logic sw_ok;
    logic rd_ok;

    // Second read port and validity for the exchange.
    always_comb begin
        sw_val = '0;
        sw_ok  = 1'b0;
        rd_ok  = 1'b0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (swap_sel == PSEL_W'(i)) begin
                sw_val = pairs[i];
                sw_ok  = 1'b1;
            end
            if (pair_sel == PSEL_W'(i)) rd_ok = 1'b1;
        end
        swap_go = swap_req && !busy && sw_ok && rd_ok
                  && (swap_sel != pair_sel);
    end
`else
    assign swap_go = 1'b0;
    assign sw_val  = '0;
`endif

    // Inc/dec datapath: byte-wide with stored carry, or full width.
    always_comb begin
        step_b   = step2_q ? (BYTE_W+1)'(2) : (BYTE_W+1)'(1);
        step_w   = step2_q ? DW'(2) : DW'(1);
        lo_sum   = dir_q ? ({1'b0, dreg[BYTE_W-1:0]} - step_b)
                         : ({1'b0, dreg[BYTE_W-1:0]} + step_b);
        hi_res   = dir_q ? (dreg[DW-1:BYTE_W] - BYTE_W'(carry_q))
                         : (dreg[DW-1:BYTE_W] + BYTE_W'(carry_q));
        full_res = dir_q ? (dreg - step_w) : (dreg + step_w);
        res      = (SERIAL != 0) ? {hi_res, dreg[BYTE_W-1:0]} : full_res;
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: IDLE -> LO -> HI or IDLE -> EXEC.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (incdec_req) state_nx = (SERIAL != 0) ? LO : EXEC;
            LO:   state_nx = HI;
            HI:   state_nx = IDLE;
            EXEC: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operation parameters latched at request, carry between halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            dir_q   <= 1'b0;
            step2_q <= 1'b0;
            wb_q    <= 1'b0;
            wb_sel  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (state == IDLE && incdec_req) begin
                dir_q   <= incdec_dir;
                step2_q <= incdec_step2;
                wb_q    <= incdec_wb;
                wb_sel  <= pair_sel;
            end
            if (state == LO) carry_q <= lo_sum[BYTE_W];
        end
    end

    // dreg: loads only while idle, arithmetic owns it while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pair_rd) begin
                        dreg <= rd_val;
                    end else begin
                        if (lo_wr) dreg[BYTE_W-1:0]  <= dbus_in;
                        if (hi_wr) dreg[DW-1:BYTE_W] <= dbus_in;
                    end
                end
                LO:      dreg[BYTE_W-1:0] <= lo_sum[BYTE_W-1:0];
                HI:      dreg <= res;
                EXEC:    dreg <= res;
                default: dreg <= dreg;
            endcase
        end
    end

    // Pair array: exchange beats pair_wr, write-back beats both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PAIRS; i++) pairs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PAIRS; i++) begin
                if (swap_go) begin
                    if (pair_sel == PSEL_W'(i))
                        pairs[i] <= sw_val;
                    else if (PSEL_W'(i) != pair_sel && sw_val != pairs[i]
                             && 1'b0)
                        pairs[i] <= pairs[i];
                end else if (pair_wr && pair_sel == PSEL_W'(i)) begin
                    pairs[i] <= dreg;
                end
`ifdef REGPAIR_SWAP_EN
                if (swap_go && swap_sel == PSEL_W'(i))
                    pairs[i] <= rd_val;
`endif
                if (wb_fire && wb_sel == PSEL_W'(i))
                    pairs[i] <= res;
            end
        end
    end

    // Registered bus drive; low half wins when both reads are asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_out <= '0;
            dbus_oe  <= 1'b0;
        end else begin
            priority case (1'b1)
                lo_rd: begin
                    dbus_out <= rd_val[BYTE_W-1:0];
                    dbus_oe  <= 1'b1;
                end
                hi_rd: begin
                    dbus_out <= rd_val[DW-1:BYTE_W];
                    dbus_oe  <= 1'b1;
                end
                default: dbus_oe <= 1'b0;
            endcase
        end
    end

endmodule
